// File: rtl/weight_fold_acc_tpsram.sv
`timescale 1ns/1ps
// weight_fold_acc_tpsram
// Two-copy weight-fold RAM: streamed overwrite / accumulate writes with
// saturating or wrapping add, a hardware clear sequencer and read-valid tracking.
// Copy A serves the user read port, copy B the accumulate operand read.
// Optional build macro WEIGHT_FOLD_ACC_PARITY_EN: each word carries an even
// parity bit and user reads report R_ERR alongside R_VALID.
// RD_LAT other than 1 is treated as 2 (output register present).
module weight_fold_acc_tpsram #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int RD_LAT = 2,
    parameter int SAT    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INIT,
    output logic              BUSY,
    input  logic              W_EN,
    input  logic              W_ACC,
    input  logic [ADDR_W-1:0] W_ADDR,
    input  logic [DATA_W-1:0] W_DATA,
    input  logic              R_EN,
    input  logic [ADDR_W-1:0] R_ADDR,
    output logic [DATA_W-1:0] R_DATA,
`ifdef WEIGHT_FOLD_ACC_PARITY_EN
    output logic              R_ERR,
`endif
    output logic              R_VALID
);

`ifdef WEIGHT_FOLD_ACC_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] S_MAX     = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN     = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    // storage copies
    logic [MEM_W-1:0]  mem_a [DEPTH];
    logic [MEM_W-1:0]  mem_b [DEPTH];

    // control
    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              busy_q;
    logic              idle;
    logic              init_fire;
    logic              req_ok;
    logic              wr_fire;
    logic              rd_fire;

    // write pipeline
    logic              s1_vld_q;
    logic              s1_acc_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [MEM_W-1:0]  b_rd_q;
    logic              lc_vld_q;
    logic [ADDR_W-1:0] lc_addr_q;
    logic [DATA_W-1:0] lc_val_q;
    logic [DATA_W-1:0] operand;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] result;
    logic              commit_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [MEM_W-1:0]  mem_wd;

    // read path
    logic [MEM_W-1:0]  a_rd_q;
    logic              a_vld_q;
    logic [MEM_W-1:0]  out_word;
    logic              out_vld;

    // Requests are only honoured in IDLE and never in the cycle INIT is taken.
    assign idle      = (state_q == ST_IDLE);
    assign init_fire = idle && INIT;
    assign req_ok    = idle && !INIT;
    assign wr_fire   = req_ok && W_EN;
    assign rd_fire   = req_ok && R_EN;
    assign BUSY      = busy_q;

    // Clear sequencer: sweeps every address once, then returns to IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    if (INIT) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
            endcase
        end
    end

    // S1 valid flag; INIT/CLEAR make wr_fire low, which drops any pending write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= wr_fire;
        end
    end

    // S1 payload capture.
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            s1_acc_q  <= W_ACC;
            s1_addr_q <= W_ADDR;
            s1_data_q <= W_DATA;
        end
    end

    // Copy-B operand read, issued together with S1 capture (old data on collision).
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            b_rd_q <= mem_b[W_ADDR];
        end
    end

    // S2: choose operand (forward the previous commit if same address) and fold.
    always_comb begin
        operand = b_rd_q[DATA_W-1:0];
        if (lc_vld_q && (lc_addr_q == s1_addr_q)) begin
            operand = lc_val_q;
        end
        sum_ext = {operand[DATA_W-1], operand} + {s1_data_q[DATA_W-1], s1_data_q};
        result  = s1_data_q;
        if (s1_acc_q) begin
            if ((SAT != 0) && (sum_ext[DATA_W] != sum_ext[DATA_W-1])) begin
                result = sum_ext[DATA_W] ? S_MIN : S_MAX;
            end else begin
                result = sum_ext[DATA_W-1:0];
            end
        end
    end

    assign commit_en = s1_vld_q && !init_fire;

    // Single write port shared by the clear sweep and the commit stage.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = s1_addr_q;
        mem_wd = '0;
        if (!idle) begin
            mem_we = 1'b1;
            mem_wa = clr_cnt_q;
        end else if (commit_en) begin
            mem_we = 1'b1;
`ifdef WEIGHT_FOLD_ACC_PARITY_EN
            mem_wd = {^result, result};
`else
            mem_wd = result;
`endif
        end
    end

    // Last-commit register feeding the accumulate forwarding path.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lc_vld_q <= 1'b0;
        end else begin
            lc_vld_q <= commit_en;
        end
        if (commit_en) begin
            lc_addr_q <= s1_addr_q;
            lc_val_q  <= result;
        end
    end

    // Copy A write (user-read copy).
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_a[mem_wa] <= mem_wd;
        end
    end

    // Copy B write (accumulate-operand copy).
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_b[mem_wa] <= mem_wd;
        end
    end

    // Copy-A registered read; holds its word between reads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_rd_q  <= '0;
            a_vld_q <= 1'b0;
        end else begin
            a_vld_q <= rd_fire;
            if (rd_fire) begin
                a_rd_q <= mem_a[R_ADDR];
            end
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign out_word = a_rd_q;
        assign out_vld  = a_vld_q;
    end else begin : g_lat2
        logic [MEM_W-1:0] out_word_q;
        logic             out_vld_q;

        // Output register; a read in flight when INIT is taken is squashed here.
        always_ff @(posedge CLK) begin
            if (RST) begin
                out_word_q <= '0;
                out_vld_q  <= 1'b0;
            end else begin
                out_vld_q <= a_vld_q && !init_fire;
                if (a_vld_q && !init_fire) begin
                    out_word_q <= a_rd_q;
                end
            end
        end

        assign out_word = out_word_q;
        assign out_vld  = out_vld_q;
    end

    assign R_DATA  = out_word[DATA_W-1:0];
    assign R_VALID = out_vld;
`ifdef WEIGHT_FOLD_ACC_PARITY_EN
    assign R_ERR   = ^out_word;
`endif

endmodule

// File: tb/tb_weight_fold_acc_tpsram.sv
`timescale 1ns/1ps
// Testbench for weight_fold_acc_tpsram: randomized and directed stimulus,
// a queue-based scoreboard fed at issue time and a negedge read monitor.
module tb_weight_fold_acc_tpsram;
    localparam int DW     = 14;
    localparam int AW     = 12;
    localparam int DEPTH  = 4096;
    localparam int RD_LAT = 2;
    localparam int SAT    = 1;
    localparam int SMAX   = (1 << (DW-1)) - 1;
    localparam int SMIN   = -(1 << (DW-1));

    logic          CLK = 1'b0;
    logic          RST;
    logic          INIT;
    logic          BUSY;
    logic          W_EN;
    logic          W_ACC;
    logic [AW-1:0] W_ADDR;
    logic [DW-1:0] W_DATA;
    logic          R_EN;
    logic [AW-1:0] R_ADDR;
    logic [DW-1:0] R_DATA;
    logic          R_VALID;
`ifdef WEIGHT_FOLD_ACC_PARITY_EN
    logic          R_ERR;
`endif

    weight_fold_acc_tpsram #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .SAT(SAT)
    ) dut (
        .CLK(CLK), .RST(RST), .INIT(INIT), .BUSY(BUSY),
        .W_EN(W_EN), .W_ACC(W_ACC), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
        .R_EN(R_EN), .R_ADDR(R_ADDR), .R_DATA(R_DATA),
`ifdef WEIGHT_FOLD_ACC_PARITY_EN
        .R_ERR(R_ERR),
`endif
        .R_VALID(R_VALID)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model: logical contents after every issued write, plus the
    // previous cycle's write (not yet visible to a read issued now).
    int model_mem [DEPTH];
    bit pw_vld;
    int pw_addr;
    int pw_old;
    bit next_err = 1'b0;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        bit            err;
    } exp_t;
    exp_t sb [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int fold(input int op, input int d, input bit acc);
        int s;
        if (!acc) return d;
        s = op + d;
        if (SAT != 0) begin
            if (s > SMAX) s = SMAX;
            if (s < SMIN) s = SMIN;
        end else begin
            if (s > SMAX) s = s - (1 << DW);
            if (s < SMIN) s = s + (1 << DW);
        end
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        pw_vld = 1'b0;
    endtask

    task automatic drive_idle();
        INIT = 1'b0; W_EN = 1'b0; W_ACC = 1'b0; W_ADDR = '0; W_DATA = '0;
        R_EN = 1'b0; R_ADDR = '0;
    endtask

    // One clock of requests; the read expectation is taken before this
    // cycle's write is folded into the model. fx forces a constant expectation.
    task automatic cycle(input bit we, input bit acc, input int wa, input int wd,
                         input bit re, input int ra, input bit fx, input int fv);
        exp_t e;
        int   ev;
        int   old;
        INIT = 1'b0;
        W_EN = we; W_ACC = acc; W_ADDR = wa[AW-1:0]; W_DATA = wd[DW-1:0];
        R_EN = re; R_ADDR = ra[AW-1:0];
        if (re) begin
            ev = (pw_vld && pw_addr == ra) ? pw_old : model_mem[ra];
            if (fx) ev = fv;
            e.due  = cyc + RD_LAT;
            e.data = ev[DW-1:0];
            e.err  = next_err;
            sb.push_back(e);
        end
        if (we) begin
            old = model_mem[wa];
            model_mem[wa] = fold(old, wd, acc);
            pw_vld = 1'b1; pw_addr = wa; pw_old = old;
        end else begin
            pw_vld = 1'b0;
        end
        @(posedge CLK); #1;
        drive_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Counts BUSY-high cycles while throwing junk requests (and optionally a
    // second INIT) at the DUT; all of them must be ignored.
    task automatic run_clear(input int n0, input int init_at);
        int  n;
        bit  done;
        n = n0;
        done = 1'b0;
        for (int i = 0; i < DEPTH + 200 && !done; i++) begin
            @(posedge CLK); #1;
            if (BUSY !== 1'b1) begin
                done = 1'b1;
            end else begin
                n++;
                W_EN = 1'($urandom_range(0, 1)); W_ACC = 1'($urandom_range(0, 1));
                W_ADDR = AW'($urandom); W_DATA = DW'($urandom);
                R_EN = 1'($urandom_range(0, 1)); R_ADDR = AW'($urandom);
                INIT = (n == init_at);
            end
        end
        drive_idle();
        check("busy_cycles", n, DEPTH);
        model_clear();
    endtask

    task automatic rand_phase(input int n);
        int wd;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) wd = int'($urandom_range(0, 100)) - 50;
            else wd = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW-1));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3,
                  int'($urandom_range(0, 7)), wd,
                  $urandom_range(0, 4) < 3,
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DEPTH-1))
                                              : int'($urandom_range(0, 7)),
                  0, 0);
        end
    endtask

    // Read monitor: every R_VALID pops one expectation; overdue ones are misses.
    always @(negedge CLK) begin
        exp_t e;
        if (RST === 1'b0) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                check("rd_missing_valid", 0, 1);
            end
            if (R_VALID === 1'b1) begin
                if (sb.size() == 0) begin
                    check("rd_unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", int'($signed(R_DATA)), int'($signed(e.data)));
                    check("rd_latency", cyc, e.due);
`ifdef WEIGHT_FOLD_ACC_PARITY_EN
                    check("rd_err", int'(R_ERR), int'(e.err));
`endif
                    $display("rd cycle=%0d data=%0d expected=%0d", cyc,
                             $signed(R_DATA), $signed(e.data));
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        drive_idle();
        model_clear();
        @(posedge CLK); #1;
        check("rst_busy", int'(BUSY), 1);
        check("rst_valid", int'(R_VALID), 0);
        check("rst_data", int'(R_DATA), 0);
        RST = 1'b0;
        run_clear(1, -1);

        // cleared corners
        cycle(0, 0, 0, 0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 2047, 1, 0);
        cycle(0, 0, 0, 0, 1, 4095, 1, 0);
        idle(3);

        // overwrite and read latency / visibility
        cycle(1, 0, 5, 'h1ABC, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 5, 1, 0);
        cycle(0, 0, 0, 0, 1, 5, 1, 'h1ABC);
        idle(2);

        // back-to-back accumulate with forwarding
        cycle(1, 0, 7, 0, 0, 0, 0, 0);
        cycle(1, 1, 7, 3, 0, 0, 0, 0);
        cycle(1, 1, 7, 4, 0, 0, 0, 0);
        cycle(1, 1, 7, -2, 0, 0, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 1, 7, 1, 5);

        // saturation at both rails
        cycle(1, 0, 9, 8190, 0, 0, 0, 0);
        cycle(1, 1, 9, 5, 0, 0, 0, 0);
        cycle(1, 0, 10, -8192, 0, 0, 0, 0);
        cycle(1, 1, 10, -1, 0, 0, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 1, 9, 1, 8191);
        cycle(0, 0, 0, 0, 1, 10, 1, -8192);
        idle(2);

`ifdef WEIGHT_FOLD_ACC_PARITY_EN
        cycle(1, 0, 3, 100, 0, 0, 0, 0);
        cycle(1, 0, 4, 77, 0, 0, 0, 0);
        idle(2);
        dut.mem_a[3][0] = ~dut.mem_a[3][0];
        next_err = 1'b1;
        cycle(0, 0, 0, 0, 1, 3, 1, 101);
        next_err = 1'b0;
        dut.mem_a[3][0] = ~dut.mem_a[3][0];
        cycle(0, 0, 0, 0, 1, 4, 1, 77);
        idle(2);
`endif

        rand_phase(600);

        // INIT with an accumulate in S1 and a read in flight
        idle(4);
        cycle(1, 1, 2, 5, 1, 2, 0, 0);
        INIT = 1'b1; W_EN = 1'b1; W_ACC = 1'b1; W_ADDR = 2; W_DATA = 9;
        R_EN = 1'b1; R_ADDR = 2;
        sb.delete();
        pw_vld = 1'b0;
        run_clear(0, 1000);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, i, 1, 0);
        for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 1, int'($urandom_range(0, DEPTH-1)), 1, 0);

        rand_phase(300);
        idle(RD_LAT + 3);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/weight_fold_acc_tpsram.md
Name: weight_fold_acc_tpsram

Overview:
- Parametrised successor to the fixed 4096x14 weight-fold two-port RAM.
- Generic width and depth; selectable read latency.
- Adds a per-write accumulate mode (read-modify-write with saturation), a hardware clear sequencer, and read-valid tracking.
- Sits between the weight-fold datapath, which streams accumulate/overwrite writes, and the downstream reader, which issues random reads.

Parameters:
- DATA_W, 14, word width in bits; stored values are two's-complement signed.
- ADDR_W, 12, address width.
- DEPTH, 2**ADDR_W, number of words; must be ≤ 2**ADDR_W.
- RD_LAT, 2, user read latency in cycles; legal values are 1 and 2 (2 adds an output register).
- SAT, 1, accumulate overflow handling: 1 = saturate to signed min/max, 0 = wrap modulo 2**DATA_W.

Ports:
- CLK  in  1  single clock; all logic is rising-edge.
- RST  in  1  synchronous, active-high reset.
- INIT  in  1  one-cycle pulse; requests a clear of the whole array.
- BUSY  out  1  high while the clear sequencer runs; requests are ignored while high.
- W_EN  in  1  write request this cycle.
- W_ACC  in  1  qualifies W_EN: 1 = accumulate (mem += W_DATA), 0 = overwrite.
- W_ADDR  in  ADDR_W  write address.
- W_DATA  in  DATA_W  write/addend data.
- R_EN  in  1  read request this cycle.
- R_ADDR  in  ADDR_W  read address.
- R_DATA  out  DATA_W  read data.
- R_VALID  out  1  R_DATA carries the result of a read issued RD_LAT cycles earlier.

Behaviour:
- Reset (RST=1 at an edge):
  - R_DATA=0, R_VALID=0, BUSY=1.
  - Write pipeline flushed; FSM enters CLEAR with clear counter=0.
  - RST asserted mid-operation aborts everything in flight.
- Storage: two identical copies, A and B.
  - Every committed write goes to both copies.
  - A serves the user read port; B serves the accumulate read.
  - Read-during-write to the same address returns OLD data on both copies.
- FSM states:
  - CLEAR: writes 0 to the counter address each cycle and increments. After address DEPTH-1 → IDLE, BUSY=0 the next cycle. Total DEPTH cycles.
  - IDLE: INIT=1 → CLEAR (counter=0, BUSY=1 the next cycle). The pending S1/S2 write is dropped and in-flight reads are squashed (R_VALID=0). INIT is ignored while in CLEAR.
- Requests while BUSY=1: W_EN and R_EN are ignored; no state change; R_VALID stays 0.
- Write pipeline, uniform for both write kinds:
  - Cycle t, S1: register addr, data and acc flag; issue a copy-B read of W_ADDR.
  - Cycle t+1, S2: operand = copy-B data, or the forwarded value (below).
    - Overwrite: result = data.
    - Accumulate: result = operand + data, computed in DATA_W+1 bits, then saturated (SAT=1) or truncated (SAT=0).
    - Result is committed at the t+1 edge, so a read issued at t+2 or later sees it.
  - Exactly one commit per cycle; commits occur in issue order.
  - A write may be issued every cycle.
- Forwarding:
  - A last-commit register holds the address/value committed in the previous cycle.
  - If the S2 address equals the last-commit address, the operand is the last-commit value instead of the copy-B data.
  - This makes back-to-back accumulates to the same address exact.
- User reads:
  - R_EN at t → R_DATA/R_VALID at t+RD_LAT.
  - A read sees writes committed at the edge ending t-1 or earlier. No forwarding on the user port: a read at t of an address committing at t returns the old value.
  - R_DATA holds its last value while R_VALID=0.
- Simultaneous read and write at any addresses are always legal.

Optional Feature:
- Macro: WEIGHT_FOLD_ACC_PARITY_EN.
- When defined:
  - Each copy stores DATA_W+1 bits: the committed result plus its even parity bit.
  - Adds output port R_ERR (1 bit), valid with R_VALID: 1 when the stored parity mismatches the read data.
  - Clear writes parity 0.
  - A copy-B parity mismatch during accumulate still commits the computed result with fresh parity; it is not flagged.
- When undefined: R_ERR does not exist; storage is DATA_W bits.

Test Plan:
- Reset clear: RST 1 cycle, DEPTH=4096 → BUSY=1 for exactly 4096 cycles; then read of addrs 0, 2047, 4095 → 0 with R_VALID at t+RD_LAT.
- Overwrite/latency, RD_LAT=2: write 0x1ABC to addr 5 at t; R_EN addr 5 at t+1 → R_DATA old (0) at t+3; R_EN at t+2 → 0x1ABC at t+4.
- Back-to-back accumulate: addr 7 = 0, then accumulate +3, +4, -2 on consecutive cycles → read returns 5.
- Saturation, SAT=1, DATA_W=14: addr 9 = 8190, accumulate +5 → 8191; addr 10 = -8192, accumulate -1 → -8192. With SAT=0: 8190+5 → -8189.
- INIT mid-stream: accumulate in S1 and a read in flight when INIT pulses → R_VALID=0, BUSY=1 for DEPTH cycles, every address reads 0 afterwards, W_EN during BUSY has no effect.
- Parity (macro on): force-flip one stored bit of copy A at addr 3, read addr 3 → R_ERR=1 with R_VALID=1; a clean address → R_ERR=0.
